// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state codes
// and the architectural zero register.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] LU_STALL = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Load-use hazard detector: the load in EX writes a register the ID
// instruction reads. Writes to $zero never create a dependency.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       memReadEx,
  input  logic [4:0] rdEx,
  input  logic [4:0] rsId,
  input  logic [4:0] rtId,
  input  logic       rtUsedId,
  output logic       luHazard
);

  assign luHazard = memReadEx && (rdEx != REG_ZERO) &&
                    ((rdEx == rsId) || (rtUsedId && (rdEx == rtId)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges memory wait states,
// taken branches and load-use hazards into per-stage write/bubble controls.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             memread_ex,
  input  logic [4:0]       rd_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             rt_used_id,
  input  logic             branch_taken_ex,
  input  logic             mem_req_mem,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int              WC_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MEM_TIMEOUT);

  logic [1:0]      state;
  logic [1:0]      stateNext;
  logic [WC_W-1:0] waitCnt;
  logic            luHit;
  logic            memWait;
  logic            luEnable;

  load_use_detect uLoadUse (
    .memReadEx (memread_ex),
    .rdEx      (rd_ex),
    .rsId      (rs_id),
    .rtId      (rt_id),
    .rtUsedId  (rt_used_id),
    .luHazard  (luHit)
  );

  assign memWait = mem_req_mem && !dmem_ready;
  // Only the cycle right after a load-use stall suppresses detection: when a
  // memory freeze lifts, a held load-use pair must still be stalled.
  assign luEnable = (state != LU_STALL);

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    stateNext    = RUN;
    if (memWait) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
      stateNext    = MEM_WAIT;
    end else if (branch_taken_ex) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (luHit && luEnable) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      stateNext   = LU_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      waitCnt     <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= stateNext;
      if (memWait) begin
        if (waitCnt != WAIT_MAX) waitCnt <= waitCnt + 1'b1;
        if (waitCnt == WAIT_MAX - 1'b1) mem_timeout <= 1'b1;
      end else begin
        waitCnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, ~pc_write};
      flush_count  <= flush_count + {{(CNT_W-1){1'b0}}, ifid_flush};
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, multi-cycle sequences and
// random stimulus against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int MT = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          memread_ex, rt_used_id, branch_taken_ex, mem_req_mem, dmem_ready;
  logic [4:0]    rd_ex, rs_id, rt_id;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble, idex_write;
  logic          exmem_write, memwb_bubble, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .memread_ex(memread_ex), .rd_ex(rd_ex), .rs_id(rs_id),
    .rt_id(rt_id), .rt_used_id(rt_used_id), .branch_taken_ex(branch_taken_ex),
    .mem_req_mem(mem_req_mem), .dmem_ready(dmem_ready), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .idex_write(idex_write), .exmem_write(exmem_write), .memwb_bubble(memwb_bubble),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Output word order: {pc, ifid_w, ifid_flush, idex_bubble, idex_w, exmem_w, memwb_bubble}
  localparam logic [6:0] O_IDLE   = 7'b1100110;
  localparam logic [6:0] O_FREEZE = 7'b0000001;
  localparam logic [6:0] O_BRANCH = 7'b1111110;
  localparam logic [6:0] O_LU     = 7'b0001110;

  typedef struct {
    string      name;
    logic       memread;
    logic [4:0] rd, rs, rt;
    logic       rtUsed, br, req, rdy;
    logic [6:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit            mPrevLu;
  int            mWaitRun;
  bit            mTimeout;
  logic [CW-1:0] mStall, mFlush;
  logic [6:0]    lastOut;

  function automatic logic [6:0] dutOut();
    return {pc_write, ifid_write, ifid_flush, idex_bubble, idex_write, exmem_write, memwb_bubble};
  endfunction

  function automatic bit modelLu();
    return memread_ex && rd_ex != 0 && (rd_ex == rs_id || (rt_used_id && rd_ex == rt_id));
  endfunction

  function automatic logic [6:0] modelOut();
    if (mem_req_mem && !dmem_ready) return O_FREEZE;
    if (branch_taken_ex) return O_BRANCH;
    if (modelLu() && !mPrevLu) return O_LU;
    return O_IDLE;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic setIn(input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ru, input logic br,
                       input logic rq, input logic ry);
    memread_ex = mr; rd_ex = rd; rs_id = rs; rt_id = rt; rt_used_id = ru;
    branch_taken_ex = br; mem_req_mem = rq; dmem_ready = ry;
  endtask

  task automatic modelReset();
    mPrevLu = 0; mWaitRun = 0; mTimeout = 0; mStall = '0; mFlush = '0;
  endtask

  // Called just after a rising edge with inputs set; ends just after the next edge.
  task automatic step(input string nm);
    logic [6:0] o;
    bit mw, nPrev, nTo;
    int nWait;
    #3;
    o = modelOut();
    lastOut = dutOut();
    check({nm, "/outputs"}, {57'd0, lastOut}, {57'd0, o});
    mw    = mem_req_mem && !dmem_ready;
    nPrev = !mw && !branch_taken_ex && modelLu() && !mPrevLu;
    nWait = mw ? ((mWaitRun < MT) ? mWaitRun + 1 : MT) : 0;
    nTo   = mTimeout || (nWait == MT);
    @(posedge clk);
    mPrevLu = nPrev; mWaitRun = nWait; mTimeout = nTo;
    mStall = mStall + {{(CW-1){1'b0}}, ~o[6]};
    mFlush = mFlush + {{(CW-1){1'b0}}, o[4]};
    #1;
    check({nm, "/stall_cycles"}, {32'd0, stall_cycles}, {32'd0, mStall});
    check({nm, "/flush_count"}, {32'd0, flush_count}, {32'd0, mFlush});
    check({nm, "/mem_timeout"}, {63'd0, mem_timeout}, {63'd0, mTimeout});
  endtask

  vec_t vecs[$];

  initial begin
    logic [CW-1:0] base;
    vecs.push_back('{"idle",        0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_IDLE});
    vecs.push_back('{"lu_rs",       1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, O_LU});
    vecs.push_back('{"lu_rd_zero",  1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_IDLE});
    vecs.push_back('{"rt_unused",   1, 5'd5, 5'd0, 5'd5, 0, 0, 0, 0, O_IDLE});
    vecs.push_back('{"lu_rt",       1, 5'd5, 5'd1, 5'd5, 1, 0, 0, 0, O_LU});
    vecs.push_back('{"no_load",     0, 5'd5, 5'd5, 5'd5, 1, 0, 0, 0, O_IDLE});
    vecs.push_back('{"branch_lu",   1, 5'd7, 5'd7, 5'd0, 0, 1, 0, 0, O_BRANCH});
    vecs.push_back('{"memwait_br",  0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, O_FREEZE});
    vecs.push_back('{"mem_ready",   0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, O_IDLE});
    vecs.push_back('{"memwait_lu",  1, 5'd3, 5'd3, 5'd0, 0, 0, 1, 0, O_FREEZE});

    // Reset state
    rst_n = 1'b0;
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    #12;
    check("reset/outputs", {57'd0, dutOut()}, {57'd0, O_IDLE});
    check("reset/stall_cycles", {32'd0, stall_cycles}, 64'd0);
    check("reset/flush_count", {32'd0, flush_count}, 64'd0);
    check("reset/mem_timeout", {63'd0, mem_timeout}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table; an idle cycle after each returns the sequencer to RUN
    foreach (vecs[i]) begin
      setIn(vecs[i].memread, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].rtUsed,
            vecs[i].br, vecs[i].req, vecs[i].rdy);
      step(vecs[i].name);
      check({vecs[i].name, "/table"}, {57'd0, lastOut}, {57'd0, vecs[i].exp});
      setIn(0, 0, 0, 0, 0, 0, 0, 0);
      step({vecs[i].name, "_recover"});
    end

    // Load-use held two cycles: one stall only
    base = mStall;
    setIn(1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0);
    step("luhold_c1");
    check("luhold_c1/stall", {57'd0, lastOut}, {57'd0, O_LU});
    step("luhold_c2");
    check("luhold_c2/idle", {57'd0, lastOut}, {57'd0, O_IDLE});
    check("luhold/stall_delta", {32'd0, stall_cycles}, {32'd0, base + 32'd1});

    // Branch with load-use: flush, no LU_STALL afterwards
    base = mFlush;
    setIn(1, 5'd9, 5'd9, 5'd0, 0, 1, 0, 0);
    step("brlu");
    check("brlu/flush", {57'd0, lastOut}, {57'd0, O_BRANCH});
    check("brlu/flush_delta", {32'd0, flush_count}, {32'd0, base + 32'd1});
    setIn(1, 5'd9, 5'd9, 5'd0, 0, 0, 0, 0);
    step("brlu_next");
    check("brlu_next/lu_stall", {57'd0, lastOut}, {57'd0, O_LU});
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    step("brlu_idle");

    // Three wait cycles then ready
    base = mStall;
    setIn(0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step("wait3");
      check("wait3/frozen", {57'd0, lastOut}, {57'd0, O_FREEZE});
    end
    setIn(0, 0, 0, 0, 0, 0, 1, 1);
    step("wait3_ready");
    check("wait3_ready/idle", {57'd0, lastOut}, {57'd0, O_IDLE});
    check("wait3/stall_delta", {32'd0, stall_cycles}, {32'd0, base + 32'd3});
    check("wait3/no_timeout", {63'd0, mem_timeout}, 64'd0);

    // Timeout after MT consecutive waits, sticky afterwards
    setIn(0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      step("wait6");
      if (k == 3) check("wait6/timeout_low", {63'd0, mem_timeout}, 64'd0);
    end
    check("wait6/timeout_high", {63'd0, mem_timeout}, 64'd1);
    setIn(0, 0, 0, 0, 0, 0, 1, 1);
    step("wait6_ready");
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    step("wait6_idle");
    check("wait6/timeout_sticky", {63'd0, mem_timeout}, 64'd1);

    // Asynchronous reset in the middle of a memory wait
    setIn(0, 0, 0, 0, 0, 0, 1, 0);
    step("prereset_wait");
    rst_n = 1'b0;
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    #1;
    check("midreset/outputs", {57'd0, dutOut()}, {57'd0, O_IDLE});
    check("midreset/stall_cycles", {32'd0, stall_cycles}, 64'd0);
    check("midreset/flush_count", {32'd0, flush_count}, 64'd0);
    check("midreset/mem_timeout", {63'd0, mem_timeout}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    setIn(1, 5'd4, 5'd0, 5'd4, 1, 0, 0, 0);
    step("postreset_lu");
    check("postreset_lu/run", {57'd0, lastOut}, {57'd0, O_LU});

    // Random stimulus against the model
    for (int n = 0; n < 600; n++) begin
      setIn(1'($urandom % 2), 5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4),
            1'($urandom % 2), 1'($urandom % 5 == 0), 1'($urandom % 3 == 0),
            1'($urandom % 3 != 0));
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
